// File: rtl/sr_pkg.sv
// Shared types and counter widths for the SR flip-flop bank writer.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  localparam int SETTLE_W = 4;
  localparam int RETRY_W  = 3;

endpackage

// File: rtl/sr_excite.sv
// Per-word SR excitation from target/current Q, plus the readback fail vector.
module sr_excite #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] fail
);

  assign s    = d & ~q;
  assign r    = ~d & q;
  // Q==Qn is an illegal bank state, so it fails even when Q matches the target.
  assign fail = (q ^ d) | ~(q ^ qn);

endmodule

// File: rtl/sr_bank_writer.sv
// Writer controller for a bank of SR flip-flops: one-cycle S/R drive, settle,
// readback check, bounded retry.
//   state  | meaning
//   IDLE   | ready for a new target word
//   DRIVE  | S/R excitation on the bank for one cycle
//   SETTLE | S/R held at 0 while the bank settles
//   CHECK  | compare Q/Qn against the target
module sr_bank_writer
  import sr_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 1,
  parameter int MAX_RETRY  = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Load_valid,
  output logic             Load_ready,
  input  logic [WIDTH-1:0] Load_data,
  input  logic [WIDTH-1:0] Q_fb,
  input  logic [WIDTH-1:0] Qn_fb,
  output logic [WIDTH-1:0] S_out,
  output logic [WIDTH-1:0] R_out,
  output logic             Done,
  output logic             Err,
  output logic [WIDTH-1:0] Mismatch
);

  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(MAX_RETRY);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    target_q, target_d;
  logic [WIDTH-1:0]    s_q, s_d;
  logic [WIDTH-1:0]    r_q, r_d;
  logic [WIDTH-1:0]    mismatch_q, mismatch_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [WIDTH-1:0]    exc_d, exc_s, exc_r, exc_fail;

  // One excitation block serves both acceptance (new data) and retry (latched target).
  assign exc_d = (state_q == IDLE) ? Load_data : target_q;

  sr_excite #(.WIDTH(WIDTH)) u_excite (
    .d    (exc_d),
    .q    (Q_fb),
    .qn   (Qn_fb),
    .s    (exc_s),
    .r    (exc_r),
    .fail (exc_fail)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    s_d        = '0;
    r_d        = '0;
    mismatch_d = mismatch_q;
    settle_d   = settle_q;
    retry_d    = retry_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (Load_valid && ready_q) begin
          target_d   = Load_data;
          s_d        = exc_s;
          r_d        = exc_r;
          err_d      = 1'b0;
          mismatch_d = '0;
          retry_d    = '0;
          ready_d    = 1'b0;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        settle_d = SETTLE_INIT;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == '0) state_d = CHECK;
        else                settle_d = settle_q - SETTLE_W'(1);
      end
      CHECK: begin
        if (exc_fail == '0) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + RETRY_W'(1);
          s_d     = exc_s;
          r_d     = exc_r;
          state_d = DRIVE;
        end else begin
          err_d      = 1'b1;
          mismatch_d = exc_fail;
          ready_d    = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      target_q   <= '0;
      s_q        <= '0;
      r_q        <= '0;
      mismatch_q <= '0;
      settle_q   <= '0;
      retry_q    <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      s_q        <= s_d;
      r_q        <= r_d;
      mismatch_q <= mismatch_d;
      settle_q   <= settle_d;
      retry_q    <= retry_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign S_out      = s_q;
  assign R_out      = r_q;
  assign Done       = done_q;
  assign Err        = err_q;
  assign Mismatch   = mismatch_q;
  assign Load_ready = ready_q;

endmodule

// File: tb/tb_sr_bank_writer.sv
// Bench for sr_bank_writer: ideal SR bank with fault injection, plus a
// transaction-level timeline model checked every cycle.
module tb_sr_bank_writer;

  localparam int W          = 4;
  localparam int SETTLE_CYC = 1;
  localparam int MAX_RETRY  = 2;
  localparam int STEP       = 2 + SETTLE_CYC;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b1;
  logic         Load_valid = 1'b0;
  logic         Load_ready;
  logic [W-1:0] Load_data = '0;
  logic [W-1:0] Q_fb, Qn_fb;
  logic [W-1:0] S_out, R_out;
  logic         Done, Err;
  logic [W-1:0] Mismatch;

  int tests = 0;
  int fails = 0;

  sr_bank_writer #(.WIDTH(W), .SETTLE_CYC(SETTLE_CYC), .MAX_RETRY(MAX_RETRY)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Load_valid (Load_valid),
    .Load_ready (Load_ready),
    .Load_data  (Load_data),
    .Q_fb       (Q_fb),
    .Qn_fb      (Qn_fb),
    .S_out      (S_out),
    .R_out      (R_out),
    .Done       (Done),
    .Err        (Err),
    .Mismatch   (Mismatch)
  );

  always #5 Clk = ~Clk;

  // Ideal rising-edge SR bank; stuck_m forces Q bits to 0, qeq_m forces Q=Qn=1.
  logic [W-1:0] bank_q  = '0;
  logic [W-1:0] stuck_m = '0;
  logic [W-1:0] qeq_m   = '0;

  always @(posedge Clk) bank_q <= ((bank_q & ~R_out) | S_out) & ~stuck_m;
  assign Q_fb  = (bank_q & ~stuck_m) | qeq_m;
  assign Qn_fb = ~Q_fb | qeq_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: on acceptance the whole write is planned as a list of
  // drive edges with their S/R words and a final outcome edge.
  int           edge_n = 0;
  logic         have_plan = 1'b0;
  int           acc_e, fin_e, na;
  logic         fin_ok;
  logic [W-1:0] fin_mm;
  int           de [8];
  logic [W-1:0] es [8];
  logic [W-1:0] er [8];

  function automatic logic busy_at(input int e);
    return have_plan && (e >= acc_e) && (e < fin_e);
  endfunction

  task automatic build_plan(input int a, input logic [W-1:0] d);
    logic [W-1:0] mq, qo, qn, fl;
    mq = bank_q & ~stuck_m;
    acc_e = a;
    have_plan = 1'b1;
    na = 0;
    for (int k = 0; k <= MAX_RETRY; k++) begin
      de[k] = a + k * STEP;
      qo    = (mq & ~stuck_m) | qeq_m;
      es[k] = d & ~qo;
      er[k] = ~d & qo;
      mq    = ((mq & ~er[k]) | es[k]) & ~stuck_m;
      qo    = (mq & ~stuck_m) | qeq_m;
      qn    = ~qo | qeq_m;
      fl    = (qo ^ d) | ~(qo ^ qn);
      na     = k + 1;
      fin_e  = de[k] + STEP;
      fin_ok = (fl == '0);
      fin_mm = fl;
      if (fl == '0) break;
    end
  endtask

  always @(posedge Clk) begin
    if (Rst_n && Load_valid && !busy_at(edge_n)) build_plan(edge_n + 1, Load_data);
    edge_n++;
  end

  always @(negedge Rst_n) have_plan = 1'b0;

  always @(negedge Clk) begin
    logic [W-1:0] xs, xr, xm;
    logic         xrdy, xd, xe;
    xs = '0; xr = '0; xm = '0; xrdy = 1'b1; xd = 1'b0; xe = 1'b0;
    if (Rst_n && have_plan) begin
      for (int k = 0; k < na; k++)
        if (de[k] == edge_n) begin xs = es[k]; xr = er[k]; end
      xrdy = !busy_at(edge_n);
      xd   = fin_ok && (edge_n == fin_e);
      xe   = !fin_ok && (edge_n >= fin_e);
      xm   = xe ? fin_mm : '0;
    end
    chk("s_out",      32'(S_out),      32'(xs));
    chk("r_out",      32'(R_out),      32'(xr));
    chk("load_ready", 32'(Load_ready), 32'(xrdy));
    chk("done",       32'(Done),       32'(xd));
    chk("err",        32'(Err),        32'(xe));
    chk("mismatch",   32'(Mismatch),   32'(xm));
    chk("s_and_r",    32'(S_out & R_out), 32'(0));
  end

  // Returns at the negedge where Done or Err is first visible; lat counts
  // edges after the acceptance edge.
  task automatic write_word(input logic [W-1:0] d, input int gap, input bit noise,
                            output int lat, output logic gd, output logic ge,
                            output logic [W-1:0] s0, output logic [W-1:0] r0,
                            output int pulses);
    int n;
    lat = 0; gd = 1'b0; ge = 1'b0; s0 = '0; r0 = '0; pulses = 0;
    repeat (gap) @(negedge Clk);
    n = 0;
    while (!Load_ready && n < 64) begin @(negedge Clk); n++; end
    if (!Load_ready) begin chk("ready_wait_timeout", 32'(0), 32'(1)); return; end
    Load_valid = 1'b1;
    Load_data  = d;
    @(posedge Clk);
    @(negedge Clk);
    Load_valid = 1'b0;
    Load_data  = W'($urandom);
    s0 = S_out;
    r0 = R_out;
    while (!(Done || Err) && lat < 64) begin
      if ((S_out | R_out) != '0) pulses++;
      if (noise) begin Load_valid = 1'($urandom); Load_data = W'($urandom); end
      @(negedge Clk);
      lat++;
    end
    Load_valid = 1'b0;
    if (!(Done || Err)) chk("done_wait_timeout", 32'(0), 32'(1));
    gd = Done;
    ge = Err;
  endtask

  initial begin
    int           lat, pulses, n;
    logic         gd, ge, ok, alt;
    logic [W-1:0] s0, r0, w;

    #1 Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Basic set from all-zero.
    write_word(4'b1010, 0, 1'b0, lat, gd, ge, s0, r0, pulses);
    chk("t1_s", 32'(s0), 32'(4'b1010));
    chk("t1_r", 32'(r0), 32'(4'b0000));
    chk("t1_pulses", 32'(pulses), 32'(1));
    chk("t1_lat", 32'(lat), 32'(3));
    chk("t1_done", 32'(gd), 32'(1));
    chk("t1_err", 32'(ge), 32'(0));
    chk("t1_q", 32'(Q_fb), 32'(4'b1010));

    // Mixed set and reset.
    write_word(4'b0110, 0, 1'b0, lat, gd, ge, s0, r0, pulses);
    chk("t2_s", 32'(s0), 32'(4'b0100));
    chk("t2_r", 32'(r0), 32'(4'b1000));
    chk("t2_done", 32'(gd), 32'(1));
    chk("t2_q", 32'(Q_fb), 32'(4'b0110));

    // Stuck-at-0 bit exhausts retries.
    write_word(4'b0000, 1, 1'b0, lat, gd, ge, s0, r0, pulses);
    stuck_m = 4'b0100;
    write_word(4'b0100, 0, 1'b0, lat, gd, ge, s0, r0, pulses);
    chk("t3_s", 32'(s0), 32'(4'b0100));
    chk("t3_pulses", 32'(pulses), 32'(3));
    chk("t3_lat", 32'(lat), 32'(9));
    chk("t3_err", 32'(ge), 32'(1));
    chk("t3_done", 32'(gd), 32'(0));
    chk("t3_mismatch", 32'(Mismatch), 32'(4'b0100));
    write_word(4'b0000, 0, 1'b0, lat, gd, ge, s0, r0, pulses);
    chk("t3_clear_done", 32'(gd), 32'(1));
    chk("t3_clear_err", 32'(Err), 32'(0));
    stuck_m = '0;

    // Q==Qn on bit 0 counts as failing.
    qeq_m = 4'b0001;
    write_word(4'b0001, 1, 1'b0, lat, gd, ge, s0, r0, pulses);
    chk("t4_err", 32'(ge), 32'(1));
    chk("t4_mismatch", 32'(Mismatch), 32'(4'b0001));
    chk("t4_pulses", 32'(pulses), 32'(0));
    chk("t4_lat", 32'(lat), 32'(9));
    qeq_m = '0;

    // Valid held high with changing data while busy.
    @(negedge Clk);
    n = 0;
    while (!Load_ready && n < 64) begin @(negedge Clk); n++; end
    Load_valid = 1'b1;
    Load_data  = 4'b0011;
    @(posedge Clk);
    alt = 1'b0; ok = 1'b0; w = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done) begin
        chk("t5_first_q", 32'(Q_fb), 32'(4'b0011));
        Load_data = alt ? 4'b1100 : 4'b0101;
        w  = Load_data;
        ok = 1'b1;
        break;
      end
      chk("t5_busy_ready", 32'(Load_ready), 32'(0));
      Load_data = alt ? 4'b1100 : 4'b0101;
      alt = ~alt;
    end
    chk("t5_done_seen", 32'(ok), 32'(1));
    @(posedge Clk);
    @(negedge Clk);
    Load_valid = 1'b0;
    chk("t5_second_accepted", 32'(Load_ready), 32'(0));
    n = 0;
    while (!Done && n < 64) begin @(negedge Clk); n++; end
    chk("t5_second_done", 32'(Done), 32'(1));
    chk("t5_second_q", 32'(Q_fb), 32'(w));

    // Reset during DRIVE.
    write_word(4'b0000, 0, 1'b0, lat, gd, ge, s0, r0, pulses);
    Load_valid = 1'b1;
    Load_data  = 4'b1111;
    @(posedge Clk);
    #1;
    chk("t6_drive_s", 32'(S_out), 32'(4'b1111));
    Load_valid = 1'b0;
    #1 Rst_n = 1'b0;
    #1;
    chk("t6_rst_s", 32'(S_out), 32'(0));
    chk("t6_rst_r", 32'(R_out), 32'(0));
    chk("t6_rst_ready", 32'(Load_ready), 32'(1));
    chk("t6_rst_done", 32'(Done), 32'(0));
    chk("t6_rst_err", 32'(Err), 32'(0));
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    write_word(4'b1111, 1, 1'b0, lat, gd, ge, s0, r0, pulses);
    chk("t6_after_done", 32'(gd), 32'(1));
    chk("t6_after_lat", 32'(lat), 32'(3));
    chk("t6_after_q", 32'(Q_fb), 32'(4'b1111));

    // Randomized writes with occasional faults and busy-time noise on valid.
    for (int it = 0; it < 150; it++) begin
      n = $urandom_range(0, 5);
      if (n == 0)      stuck_m = W'($urandom);
      else if (n == 1) qeq_m = W'(1 << $urandom_range(0, W - 1));
      else if (n <= 3) begin stuck_m = '0; qeq_m = '0; end
      write_word(W'($urandom), $urandom_range(0, 2), 1'b1, lat, gd, ge, s0, r0, pulses);
    end
    stuck_m = '0;
    qeq_m   = '0;
    repeat (4) @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
